// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    // Widest request vector rr_pick can search.
    localparam int unsigned RR_MAX = 32;

    // First set bit of valid[n-1:0], searching cyclically upward from ptr; ptr when none set.
    function automatic logic [31:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input logic [31:0]       ptr,
        input logic [31:0]       n
    );
        logic [31:0] idx;
        rr_pick = ptr;
        for (int unsigned i = 0; i < n; i++) begin
            idx = ptr + (n - 1 - i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (|(valid & (RR_MAX'(1) << idx))) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_picker.sv
// Combinational cyclic priority encoder selecting the idle-state owner.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx
);

    logic [RR_MAX-1:0] w_valid_ext;
    logic [31:0]       w_pick;

    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[NUM_REQ-1:0] = i_valid;
        w_pick                   = rr_pick(w_valid_ext, 32'(i_ptr), NUM_REQ);
        o_idx                    = IDX_W'(w_pick);
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing the FIFO push port between NUM_REQ producers,
// holding ownership for bursts of up to MAX_BURST transfers.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH:0]   req_data_i,
    output logic [NUM_REQ-1:0]                 req_grant_o,
    output logic                               push_valid_o,
    output logic [DATA_WIDTH:0]                push_data_o,
    input  logic                               push_grant_i,
    output logic [$clog2(NUM_REQ)-1:0]         owner_o,
    output logic                               locked_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_burst_cnt;

    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_owner;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_owner_valid;
    logic             w_xfer;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_valid (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_owner       = (r_state == ARB_LOCKED) ? r_owner : w_pick_idx;
        w_owner_valid = req_valid_i[w_owner];
        w_next_ptr    = (w_owner == IDX_W'(NUM_REQ - 1)) ? '0 : w_owner + IDX_W'(1);
    end

    // Outputs are forced quiet while reset is held, independent of the inputs.
    always_comb begin
        push_valid_o = !rst && w_owner_valid;
        push_data_o  = push_valid_o ? req_data_i[w_owner] : '0;
        w_xfer       = push_valid_o && push_grant_i;
        req_grant_o  = '0;
        if (w_xfer) begin
            req_grant_o[w_owner] = 1'b1;
        end
        owner_o  = rst ? '0 : w_owner;
        locked_o = (r_state == ARB_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_xfer) begin
                        if (MAX_BURST > 1) begin
                            r_owner     <= w_owner;
                            r_burst_cnt <= CNT_W'(1);
                            r_state     <= ARB_LOCKED;
                        end else begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // A stalled FIFO keeps the burst; only a dropped valid or the last beat releases.
                    if (!w_owner_valid || (w_xfer && r_burst_cnt == CNT_W'(MAX_BURST - 1))) begin
                        r_rr_ptr    <= w_next_ptr;
                        r_burst_cnt <= '0;
                        r_state     <= ARB_IDLE;
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-level model,
// driving a MAX_BURST=4 instance and a MAX_BURST=1 instance from the same producers.
module tb_fifo_push_arbiter;

    logic            clk;
    logic            rst;
    logic [3:0]      valid;
    logic [3:0][32:0] data;
    logic            pgrant;

    logic [3:0]  a_grant, b_grant;
    logic        a_pv, b_pv;
    logic [32:0] a_pdata, b_pdata;
    logic [1:0]  a_owner, b_owner;
    logic        a_locked, b_locked;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: index 0 models MAX_BURST=4, index 1 models MAX_BURST=1.
    int MB[2] = '{4, 1};
    int m_busy[2];
    int m_owner[2];
    int m_cnt[2];
    int m_ptr[2];

    fifo_push_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid_i(valid), .req_data_i(data),
        .req_grant_o(a_grant), .push_valid_o(a_pv), .push_data_o(a_pdata),
        .push_grant_i(pgrant), .owner_o(a_owner), .locked_o(a_locked)
    );

    fifo_push_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(1)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid_i(valid), .req_data_i(data),
        .req_grant_o(b_grant), .push_valid_o(b_pv), .push_data_o(b_pdata),
        .push_grant_i(pgrant), .owner_o(b_owner), .locked_o(b_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_owner[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
        end
    endtask

    function automatic int m_cur_owner(int d);
        int idx;
        if (m_busy[d] != 0) return m_owner[d];
        for (int i = 0; i < 4; i++) begin
            idx = (m_ptr[d] + i) % 4;
            if (valid[idx[1:0]]) return idx;
        end
        return m_ptr[d];
    endfunction

    task automatic model_posedge();
        for (int d = 0; d < 2; d++) begin
            int  o;
            bit  x;
            bit  rel;
            o   = m_cur_owner(d);
            x   = valid[o[1:0]] && pgrant;
            rel = 0;
            if (x) begin
                m_cnt[d]++;
                if (m_cnt[d] >= MB[d]) rel = 1;
                else begin m_busy[d] = 1; m_owner[d] = o; end
            end else if (m_busy[d] != 0 && !valid[o[1:0]]) begin
                rel = 1;
            end
            if (rel) begin
                m_busy[d] = 0; m_cnt[d] = 0; m_ptr[d] = (o + 1) % 4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = '0; pgrant = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_posedge();
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk); #1;
        n_chk++; if (a_pv !== 1'b0) begin n_err++; $display("FAIL rst_pv: got %b expected 0", a_pv); end
        n_chk++; if (a_grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b expected 0000", a_grant); end
        n_chk++; if (a_owner !== 2'd0) begin n_err++; $display("FAIL rst_owner: got %0d expected 0", a_owner); end
        n_chk++; if (a_pdata !== 33'd0) begin n_err++; $display("FAIL rst_data: got %h expected 0", a_pdata); end
        n_chk++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b expected 0", a_locked); end
        @(negedge clk);
        rst = 1'b0; #1;
        n_chk++; if (a_grant !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant: got %b expected 0001", a_grant); end
        tick();
    endtask

    task automatic test_rotation();
        int sent[4];
        logic [32:0] exp_d;
        logic [3:0]  exp_g;
        do_reset();
        for (int k = 0; k < 4; k++) sent[k] = 0;
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            valid = 4'hF; pgrant = 1'b1;
            for (int k = 0; k < 4; k++) data[k] = 33'(k * 16 + sent[k] % 4);
            #1;
            exp_d = 33'(((j / 4) % 4) * 16 + j % 4);
            exp_g = 4'(1) << ((j / 4) % 4);
            n_chk++; if (a_pdata !== exp_d) begin n_err++; $display("FAIL rot_data[%0d]: got %h expected %h", j, a_pdata, exp_d); end
            n_chk++; if (a_grant !== exp_g) begin n_err++; $display("FAIL rot_grant[%0d]: got %b expected %b", j, a_grant, exp_g); end
            tick();
            sent[(j / 4) % 4]++;
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int j = 0; j < 2; j++) begin
            @(negedge clk); valid = 4'b0100; pgrant = 1'b1; #1;
            n_chk++; if (a_grant !== 4'b0100) begin n_err++; $display("FAIL drop_grant[%0d]: got %b expected 0100", j, a_grant); end
            tick();
        end
        @(negedge clk); valid = 4'b0000; #1;
        n_chk++; if (a_grant !== 4'b0000 || a_pv !== 1'b0) begin n_err++; $display("FAIL drop_idle: got grant=%b pv=%b expected 0000/0", a_grant, a_pv); end
        tick();
        @(negedge clk); valid = 4'b1001; #1;
        n_chk++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL drop_unlocked: got %b expected 0", a_locked); end
        n_chk++; if (a_grant !== 4'b1000) begin n_err++; $display("FAIL drop_next: got %b expected 1000", a_grant); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk); valid = 4'b0010; pgrant = 1'b1; #1;
        n_chk++; if (a_grant !== 4'b0010) begin n_err++; $display("FAIL bp_first: got %b expected 0010", a_grant); end
        tick();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); pgrant = 1'b0; #1;
            n_chk++; if (a_grant !== 4'b0000 || a_owner !== 2'd1 || a_locked !== 1'b1)
                begin n_err++; $display("FAIL bp_stall[%0d]: got grant=%b owner=%0d locked=%b expected 0000/1/1", j, a_grant, a_owner, a_locked); end
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); pgrant = 1'b1; valid = 4'b1011; #1;
            n_chk++; if (a_grant !== 4'b0010) begin n_err++; $display("FAIL bp_resume[%0d]: got %b expected 0010", j, a_grant); end
            tick();
        end
        @(negedge clk); #1;
        n_chk++; if (a_grant !== 4'b1000 || a_owner !== 2'd3) begin n_err++; $display("FAIL bp_rotate: got grant=%b owner=%0d expected 1000/3", a_grant, a_owner); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int j = 0; j < 2; j++) begin
            @(negedge clk); valid = 4'b0010; pgrant = 1'b1; #1;
            n_chk++; if (a_grant !== 4'b0010) begin n_err++; $display("FAIL mid_pre[%0d]: got %b expected 0010", j, a_grant); end
            tick();
        end
        @(negedge clk); rst = 1'b1; valid = 4'hF; model_reset(); #1;
        n_chk++; if (a_pv !== 1'b0 || a_pdata !== 33'd0 || a_grant !== 4'b0 || a_locked !== 1'b0 || a_owner !== 2'd0)
            begin n_err++; $display("FAIL mid_rst: got pv=%b data=%h grant=%b locked=%b owner=%0d expected all 0", a_pv, a_pdata, a_grant, a_locked, a_owner); end
        @(negedge clk); rst = 1'b0; valid = 4'b0110;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            if (j < 4) begin
                n_chk++; if (a_grant !== 4'b0010 || a_locked !== (j > 0))
                    begin n_err++; $display("FAIL mid_burst[%0d]: got grant=%b locked=%b expected 0010/%0d", j, a_grant, a_locked, j > 0); end
            end else begin
                n_chk++; if (a_grant !== 4'b0100) begin n_err++; $display("FAIL mid_after: got %b expected 0100", a_grant); end
            end
            tick();
        end
    endtask

    task automatic test_burst1();
        logic [32:0] exp_d;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            data[k][31:0] = 32'(10 + k);
            data[k][32]   = 1'(k % 2);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); valid = 4'hF; pgrant = 1'b1; #1;
            exp_d = {1'((j % 4) % 2), 32'(10 + j % 4)};
            n_chk++; if (b_pdata !== exp_d) begin n_err++; $display("FAIL mb1_data[%0d]: got %h expected %h", j, b_pdata, exp_d); end
            n_chk++; if (b_locked !== 1'b0) begin n_err++; $display("FAIL mb1_locked[%0d]: got %b expected 0", j, b_locked); end
            n_chk++; if (b_grant !== (4'(1) << (j % 4))) begin n_err++; $display("FAIL mb1_grant[%0d]: got %b expected %b", j, b_grant, 4'(1) << (j % 4)); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (!valid[k]) begin
                    data[k][31:0] = $urandom;
                    data[k][32]   = 1'($urandom_range(0, 1));
                end
            end
            valid  = 4'($urandom_range(0, 15));
            pgrant = ($urandom_range(0, 3) != 0);
            #1;
            for (int d = 0; d < 2; d++) begin
                int          o;
                logic [3:0]  g_grant;
                logic        g_pv, g_locked;
                logic [32:0] g_data, e_data;
                logic [1:0]  g_owner;
                logic        e_pv;
                o        = m_cur_owner(d);
                e_pv     = valid[o[1:0]];
                e_data   = e_pv ? data[o[1:0]] : 33'd0;
                g_grant  = (d == 0) ? a_grant  : b_grant;
                g_pv     = (d == 0) ? a_pv     : b_pv;
                g_data   = (d == 0) ? a_pdata  : b_pdata;
                g_owner  = (d == 0) ? a_owner  : b_owner;
                g_locked = (d == 0) ? a_locked : b_locked;
                n_chk++; if (g_owner !== 2'(o)) begin n_err++; $display("FAIL rnd_owner d%0d c%0d: got %0d expected %0d", d, c, g_owner, o); end
                n_chk++; if (g_pv !== e_pv || g_data !== e_data)
                    begin n_err++; $display("FAIL rnd_push d%0d c%0d: got %b/%h expected %b/%h", d, c, g_pv, g_data, e_pv, e_data); end
                n_chk++; if (g_grant !== ((e_pv && pgrant) ? (4'(1) << o) : 4'd0))
                    begin n_err++; $display("FAIL rnd_grant d%0d c%0d: got %b expected %b", d, c, g_grant, (e_pv && pgrant) ? (4'(1) << o) : 4'd0); end
                n_chk++; if (g_locked !== (m_busy[d] != 0))
                    begin n_err++; $display("FAIL rnd_locked d%0d c%0d: got %b expected %0d", d, c, g_locked, m_busy[d]); end
            end
            tick();
        end
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 4'hF;
        pgrant = 1'b1;
        data   = '0;
        test_reset();
        test_rotation();
        test_drop();
        test_backpressure();
        test_reset_mid_burst();
        test_burst1();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
